control_unit: RTL
=================

Name: control_unit

Overview:
- Fetch/decode/execute sequencer for the matrix-multiply processor.
- Drives the PC into the instruction RAM, which has a synchronous 1-cycle read, and latches the returned 20-bit instruction.
- Decodes the instruction into one-cycle datapath strobes and waits on data-memory handshakes.
- Resolves JMP/JMPZ and halts on END.
- Sits between the instruction RAM, the register file/ALU and the data RAM.

Parameters:
- PC_W, 6, program counter width (64-word program space).
- INSTR_W, 20, instruction width.
- OPC_W, 4, opcode field width.

Ports:
- clk  in  1  system clock, all state on posedge.
- rst  in  1  synchronous active-high reset.
- start  in  1  pulse; begins execution from PC=0 when idle or halted.
- instr_in  in  20  instruction from instruction RAM, valid the cycle after pc_out is presented.
- z_flag  in  1  ALU zero flag (result of the most recent SUB).
- mem_ready  in  1  data RAM has completed the current read/write.
- pc_out  out  6  program counter to instruction RAM.
- alu_op  out  4  opcode of the executing instruction (0 when no exec).
- ra_sel  out  4  instr[15:12].
- rb_sel  out  4  instr[11:8].
- imm  out  12  instr[11:0].
- exec_en  out  1  one-cycle strobe; datapath performs alu_op on ra/rb/imm.
- mem_rd_en  out  1  held during LOAD/LOADI until mem_ready.
- mem_wr_en  out  1  held during STORE until mem_ready.
- busy  out  1  high in every state except IDLE/HALT.
- done  out  1  high in HALT.

Behaviour:
Opcodes (instr[19:16]):
- 0010 RST, 0011 WRITE, 0100 LOADI, 0101 MUL, 0110 LOAD, 0111 MV, 1000 ADD, 1001 INC, 1010 SUB, 1011 JMPZ, 1100 JMP, 1101 STORE, 1110 END.
- 0000, 0001, 1111 are NOP: no strobes, PC+1.
- Jump target is instr[15:10].

States: IDLE, FETCH, DECODE, EXEC, MEMWAIT, HALT.
- Reset: state=IDLE, pc_out=0, IR=0, all strobes 0, busy=0, done=0. Applies from any state, including mid-MEMWAIT; strobes drop the same edge.
- IDLE/HALT: on start go to FETCH with pc_out=0.
- FETCH: pc_out stable; IRAM samples it on this edge → DECODE.
- DECODE: IR<=instr_in.
  - END → HALT.
  - NOP → FETCH with PC+1.
  - Otherwise → EXEC.
- EXEC: single cycle. alu_op/ra_sel/rb_sel/imm driven from IR.
  - Memory ops (LOAD, LOADI, STORE): assert mem_rd_en or mem_wr_en, → MEMWAIT; exec_en stays 0.
  - All others: exec_en=1, then:
    - JMP: PC<=target.
    - JMPZ: PC<=target if z_flag=1 (sampled this cycle), else PC+1.
    - All other non-memory ops: PC+1.
  - Next state FETCH.
- MEMWAIT: hold the mem enable and fields. On mem_ready=1: exec_en=1 for that cycle, enable drops next edge, PC+1 → FETCH. No timeout.
- Latency: 3 cycles per non-memory instruction; 3 + wait cycles for memory ops.
- PC increment wraps 63→0.
- start while busy is ignored.
- Simultaneous rst and start: rst wins.
- mem_ready outside MEMWAIT is ignored.

Optional Feature:
- Macro SINGLE_STEP_EN.
- Defined: adds input port step (1 bit) and state STEP. After every instruction retires (FETCH would be next), enter STEP. On step=1, go to FETCH. busy stays 1 in STEP.
- Undefined: no step port; retire goes directly to FETCH.

Decomposition:
- Shared package cpu_pkg holds:
  - opcode localparams (OP_RST … OP_END);
  - state encoding;
  - field bit positions (OPC_HI=19, RA_HI=15, RB_HI=11, TGT_HI=15/TGT_LO=10);
  - PC_W and INSTR_W.
- One sub-module is natural: instr_decoder, combinational, mapping IR to is_mem, is_jump, is_end, is_nop and field outputs.
- The FSM and PC register stay in control_unit.

Test Plan:
- Program WRITE Ax 0 (0x31000), END at 1 → start; exec_en pulses once with alu_op=3, ra_sel=1, imm=0; done=1 at cycle 6; pc_out=1.
- LOADI 3072 into Rx with mem_ready delayed 4 cycles → mem_rd_en high exactly 5 cycles, exec_en on the mem_ready cycle, then PC=1.
- JMPZ 33 at PC=20:
  - z_flag=1 → next fetch pc_out=33;
  - z_flag=0 → pc_out=21.
- JMP 12 at PC=63 → pc_out=12. Separately, a NOP at 63 → pc_out wraps to 0.
- rst asserted during MEMWAIT of a STORE → mem_wr_en=0, state IDLE, pc_out=0 next cycle. A later start refetches PC 0.
- Full 46-word matmul program with a behavioural data RAM (Rx=2, Cx=2, Cy=2) → reaches done; Az region holds the 2×2 product.

Source files
------------

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared widths, opcodes, field positions and FSM states; S_STEP exists only with SINGLE_STEP_EN
package cpu_pkg;

  localparam int PC_W    = 6;
  localparam int INSTR_W = 20;
  localparam int OPC_W   = 4;

  // Instruction field positions
  localparam int OPC_HI = 19;
  localparam int OPC_LO = 16;
  localparam int RA_HI  = 15;
  localparam int RA_LO  = 12;
  localparam int RB_HI  = 11;
  localparam int RB_LO  = 8;
  localparam int IMM_HI = 11;
  localparam int TGT_HI = 15;
  localparam int TGT_LO = 10;

  // Opcodes
  localparam logic [OPC_W-1:0] OP_NOP0  = 4'h0;
  localparam logic [OPC_W-1:0] OP_NOP1  = 4'h1;
  localparam logic [OPC_W-1:0] OP_RST   = 4'h2;
  localparam logic [OPC_W-1:0] OP_WRITE = 4'h3;
  localparam logic [OPC_W-1:0] OP_LOADI = 4'h4;
  localparam logic [OPC_W-1:0] OP_MUL   = 4'h5;
  localparam logic [OPC_W-1:0] OP_LOAD  = 4'h6;
  localparam logic [OPC_W-1:0] OP_MV    = 4'h7;
  localparam logic [OPC_W-1:0] OP_ADD   = 4'h8;
  localparam logic [OPC_W-1:0] OP_INC   = 4'h9;
  localparam logic [OPC_W-1:0] OP_SUB   = 4'hA;
  localparam logic [OPC_W-1:0] OP_JMPZ  = 4'hB;
  localparam logic [OPC_W-1:0] OP_JMP   = 4'hC;
  localparam logic [OPC_W-1:0] OP_STORE = 4'hD;
  localparam logic [OPC_W-1:0] OP_END   = 4'hE;
  localparam logic [OPC_W-1:0] OP_NOPF  = 4'hF;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEMWAIT,
    S_HALT
`ifdef SINGLE_STEP_EN
    , S_STEP
`endif
  } state_t;

endpackage

// File: rtl/instr_decoder.sv
// rtl/instr_decoder.sv - combinational instruction classifier and field splitter
module instr_decoder
  import cpu_pkg::*;
(
  input  logic [INSTR_W-1:0] instr_i,
  output logic [OPC_W-1:0]   opcode_o,
  output logic [3:0]         ra_o,
  output logic [3:0]         rb_o,
  output logic [11:0]        imm_o,
  output logic [PC_W-1:0]    target_o,
  output logic               is_mem_o,
  output logic               is_load_o,
  output logic               is_jump_o,
  output logic               is_cond_o,
  output logic               is_end_o,
  output logic               is_nop_o
);

  assign opcode_o = instr_i[OPC_HI:OPC_LO];
  assign ra_o     = instr_i[RA_HI:RA_LO];
  assign rb_o     = instr_i[RB_HI:RB_LO];
  assign imm_o    = instr_i[IMM_HI:0];
  assign target_o = instr_i[TGT_HI:TGT_LO];

  // Classify the opcode into the sequencing categories the FSM cares about
  always_comb begin
    is_mem_o  = 1'b0;
    is_load_o = 1'b0;
    is_jump_o = 1'b0;
    is_cond_o = 1'b0;
    is_end_o  = 1'b0;
    is_nop_o  = 1'b0;
    case (opcode_o)
      OP_LOAD, OP_LOADI: begin
        is_mem_o  = 1'b1;
        is_load_o = 1'b1;
      end
      OP_STORE: is_mem_o = 1'b1;
      OP_JMP:   is_jump_o = 1'b1;
      OP_JMPZ: begin
        is_jump_o = 1'b1;
        is_cond_o = 1'b1;
      end
      OP_END:                    is_end_o = 1'b1;
      OP_NOP0, OP_NOP1, OP_NOPF: is_nop_o = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// rtl/control_unit.sv - fetch/decode/execute sequencer; SINGLE_STEP_EN adds a step input and STEP state
module control_unit
  import cpu_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
`ifdef SINGLE_STEP_EN
  input  logic               step,
`endif
  input  logic [INSTR_W-1:0] instr_in,
  input  logic               z_flag,
  input  logic               mem_ready,
  output logic [PC_W-1:0]    pc_out,
  output logic [OPC_W-1:0]   alu_op,
  output logic [3:0]         ra_sel,
  output logic [3:0]         rb_sel,
  output logic [11:0]        imm,
  output logic               exec_en,
  output logic               mem_rd_en,
  output logic               mem_wr_en,
  output logic               busy,
  output logic               done
);

  // Where a retired instruction sends the sequencer
`ifdef SINGLE_STEP_EN
  localparam state_t RETIRE_ST = S_STEP;
`else
  localparam state_t RETIRE_ST = S_FETCH;
`endif

  state_t             state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic [INSTR_W-1:0] ir_q, ir_d;

  logic [INSTR_W-1:0] dec_src;
  logic [OPC_W-1:0]   dec_opcode;
  logic [PC_W-1:0]    dec_target;
  logic               dec_is_mem, dec_is_load, dec_is_jump, dec_is_cond;
  logic               dec_is_end, dec_is_nop;

  // DECODE must branch on the word arriving from the RAM before it is latched;
  // every other state works from the latched IR. Fields therefore show the
  // incoming word during DECODE, which the datapath ignores without exec_en.
  assign dec_src = (state_q == S_DECODE) ? instr_in : ir_q;

  instr_decoder u_dec (
    .instr_i   (dec_src),
    .opcode_o  (dec_opcode),
    .ra_o      (ra_sel),
    .rb_o      (rb_sel),
    .imm_o     (imm),
    .target_o  (dec_target),
    .is_mem_o  (dec_is_mem),
    .is_load_o (dec_is_load),
    .is_jump_o (dec_is_jump),
    .is_cond_o (dec_is_cond),
    .is_end_o  (dec_is_end),
    .is_nop_o  (dec_is_nop)
  );

  assign pc_out = pc_q;

  // State, PC and instruction register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
    end
  end

  // Next-state, PC update and one-cycle datapath strobes
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    alu_op    = '0;
    exec_en   = 1'b0;
    mem_rd_en = 1'b0;
    mem_wr_en = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    case (state_q)
      S_IDLE, S_HALT: begin
        busy = 1'b0;
        done = (state_q == S_HALT);
        if (start) begin
          state_d = S_FETCH;
          pc_d    = '0;
        end
      end
      S_FETCH: state_d = S_DECODE;
      S_DECODE: begin
        ir_d = instr_in;
        if (dec_is_end) begin
          state_d = S_HALT;
        end else if (dec_is_nop) begin
          pc_d    = pc_q + PC_W'(1);
          state_d = RETIRE_ST;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        alu_op = dec_opcode;
        if (dec_is_mem) begin
          mem_rd_en = dec_is_load;
          mem_wr_en = !dec_is_load;
          state_d   = S_MEMWAIT;
        end else begin
          exec_en = 1'b1;
          if (dec_is_jump && (!dec_is_cond || z_flag)) begin
            pc_d = dec_target;
          end else begin
            pc_d = pc_q + PC_W'(1);
          end
          state_d = RETIRE_ST;
        end
      end
      S_MEMWAIT: begin
        alu_op    = dec_opcode;
        mem_rd_en = dec_is_load;
        mem_wr_en = !dec_is_load;
        if (mem_ready) begin
          exec_en = 1'b1;
          pc_d    = pc_q + PC_W'(1);
          state_d = RETIRE_ST;
        end
      end
`ifdef SINGLE_STEP_EN
      S_STEP: begin
        if (step) begin
          state_d = S_FETCH;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

endmodule
